// File: rtl/float_pkg.sv
// Shared definitions for the float adder back end: sum-format field positions,
// exponent limits, packing helpers and the normalizer state encoding.
package float_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int MANT_W = FRAC_W + 4;
  localparam int SUM_W  = MANT_W + 1;
  localparam int WORD_W = 1 + EXP_W + FRAC_W;

  localparam int SIGN_BIT   = 27;
  localparam int CARRY_BIT  = 26;
  localparam int HIDDEN_BIT = 25;
  localparam int GUARD_BIT  = 1;
  localparam int STICKY_BIT = 0;

  // Internal exponent is one bit wider so overflow is seen without wrap-around.
  localparam logic [EXP_W:0]    EXP_MAX   = 9'd255;
  localparam logic [WORD_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic logic [WORD_W-1:0] pack_inf(input logic sign);
    pack_inf = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  endfunction

endpackage

// File: rtl/float_round_rne.sv
// Combinational round-to-nearest-even on a normalized mantissa, with a
// one-place renormalization when the increment carries past the hidden bit.
module float_round_rne
  import float_pkg::*;
(
  input  logic [HIDDEN_BIT:0] mant,
  input  logic                sticky,
  input  logic [EXP_W:0]      exp,
  output logic [FRAC_W-1:0]   frac,
  output logic [EXP_W-1:0]    exp_out,
  output logic                ovf
);

  logic        guard_b;
  logic        sticky_b;
  logic        lsb_b;
  logic        inc;
  logic [24:0] sum;
  logic [EXP_W:0] exp_adj;

  always_comb begin
    guard_b  = mant[GUARD_BIT];
    sticky_b = mant[STICKY_BIT] | sticky;
    lsb_b    = mant[GUARD_BIT+1];
    inc      = guard_b & (sticky_b | lsb_b);
    // sum[0] aligns with mant[2]; sum[24] is the carry into the old bit 26.
    sum      = {1'b0, mant[HIDDEN_BIT:GUARD_BIT+1]} + {24'd0, inc};
    if (sum[24]) begin
      frac    = sum[23:1];
      exp_adj = exp + 9'd1;
    end else begin
      frac    = sum[22:0];
      exp_adj = exp;
    end
    ovf     = (exp_adj >= EXP_MAX);
    exp_out = exp_adj[EXP_W-1:0];
  end

endmodule

// File: rtl/float_normalizer.sv
// Normalizes the raw adder sum one shift per cycle, rounds RNE and packs an
// IEEE-754 single; one operation in flight, valid/ready on both sides.
module float_normalizer
  import float_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SUM_W-1:0]  sum_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] result,
  output logic              ovf,
  output logic              zero
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the sender holds its data stable until that edge.

  state_t              state, state_n;
  logic                sign, sign_n;
  logic [MANT_W-1:0]   mant, mant_n;
  logic [EXP_W:0]      exp, exp_n;
  logic                sticky, sticky_n;
  logic [WORD_W-1:0]   result_n;
  logic                ovf_n, zero_n;

  logic [FRAC_W-1:0]   rnd_frac;
  logic [EXP_W-1:0]    rnd_exp;
  logic                rnd_ovf;

  float_round_rne u_round (
    .mant    (mant[HIDDEN_BIT:0]),
    .sticky  (sticky),
    .exp     (exp),
    .frac    (rnd_frac),
    .exp_out (rnd_exp),
    .ovf     (rnd_ovf)
  );

  assign in_ready  = (state == IDLE) && res;
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state  <= IDLE;
      sign   <= 1'b0;
      mant   <= '0;
      exp    <= '0;
      sticky <= 1'b0;
      result <= ZERO_WORD;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      state  <= state_n;
      sign   <= sign_n;
      mant   <= mant_n;
      exp    <= exp_n;
      sticky <= sticky_n;
      result <= result_n;
      ovf    <= ovf_n;
      zero   <= zero_n;
    end
  end

  always_comb begin
    state_n  = state;
    sign_n   = sign;
    mant_n   = mant;
    exp_n    = exp;
    sticky_n = sticky;
    result_n = result;
    ovf_n    = ovf;
    zero_n   = zero;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_n   = sum_in[SIGN_BIT];
          mant_n   = sum_in[CARRY_BIT:0];
          exp_n    = {1'b0, exp_in};
          sticky_n = sum_in[STICKY_BIT];
          result_n = ZERO_WORD;
          ovf_n    = 1'b0;
          zero_n   = 1'b0;
          state_n  = NORM;
        end
      end
      NORM: begin
        if (exp == EXP_MAX) begin
          result_n = pack_inf(sign);
          ovf_n    = 1'b1;
          state_n  = HOLD;
        end else if ((mant == '0) || (exp == '0)) begin
          result_n = ZERO_WORD;
          zero_n   = 1'b1;
          state_n  = HOLD;
        end else if (mant[CARRY_BIT]) begin
          mant_n   = {1'b0, mant[MANT_W-1:1]};
          sticky_n = sticky | mant[0];
          exp_n    = exp + 9'd1;
          state_n  = ROUND;
        end else if (mant[HIDDEN_BIT]) begin
          state_n  = ROUND;
        end else if (exp == 9'd1) begin
          // Would go denormal on the next shift: flush instead.
          result_n = ZERO_WORD;
          zero_n   = 1'b1;
          state_n  = HOLD;
        end else begin
          mant_n   = {mant[MANT_W-2:0], 1'b0};
          exp_n    = exp - 9'd1;
        end
      end
      ROUND: begin
        result_n = rnd_ovf ? pack_inf(sign) : {sign, rnd_exp, rnd_frac};
        ovf_n    = rnd_ovf;
        state_n  = HOLD;
      end
      HOLD: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
